// File: rtl/ex_muldiv_if.sv
// EX-stage bundle between the issue side (master) and the ALU/mul-div stage (slave).
//   in_valid, A, B, op, rd_ALU, flush : instruction and kill from upstream
//   stall                               : upstream must hold while high
//   valid_DM, rd_DM, result_DM          : registered result towards DM
//   flag_E, flag_GT                     : registered compare flags
interface ex_muldiv_if;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic [4:0]  rd_ALU;
    logic        flush;
    logic        stall;
    logic        valid_DM;
    logic [4:0]  rd_DM;
    logic [31:0] result_DM;
    logic        flag_E;
    logic        flag_GT;

    modport master (
        output in_valid, A, B, op, rd_ALU, flush,
        input  stall, valid_DM, rd_DM, result_DM, flag_E, flag_GT
    );

    modport slave (
        input  in_valid, A, B, op, rd_ALU, flush,
        output stall, valid_DM, rd_DM, result_DM, flag_E, flag_GT
    );
endinterface

// File: rtl/ex_muldiv_stage.sv
// EX stage: single-cycle ALU plus 32-iteration sequential mul/div/mod.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ex_muldiv_if.slave (operands/op/rd in, stall and registered results out)
module ex_muldiv_stage (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 5;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_MUL = 4'd2;
    localparam logic [OPW-1:0] OP_DIV = 4'd3;
    localparam logic [OPW-1:0] OP_MOD = 4'd4;
    localparam logic [OPW-1:0] OP_CMP = 4'd5;
    localparam logic [OPW-1:0] OP_AND = 4'd6;
    localparam logic [OPW-1:0] OP_OR  = 4'd7;
    localparam logic [OPW-1:0] OP_NOT = 4'd8;
    localparam logic [OPW-1:0] OP_MOV = 4'd9;
    localparam logic [OPW-1:0] OP_LSL = 4'd10;
    localparam logic [OPW-1:0] OP_LSR = 4'd11;
    localparam logic [OPW-1:0] OP_ASR = 4'd12;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt_q, cnt_n;
    logic [OPW-1:0]  op_q, op_n;
    logic            neg_q, neg_n, dz_q, dz_n;
    logic [RIDX-1:0] rd_q, rd_n, rd_dm_q, rd_dm_n;
    logic [XLEN-1:0] opa_q, opa_n, opb_q, opb_n, result_q, result_n;
    logic [XLEN:0]   acc_q, acc_n;
    logic            valid_q, valid_n, fe_q, fe_n, fgt_q, fgt_n;

    logic [XLEN-1:0] alu_res, mag_a, mag_b, mul_sum, it_a, it_b, it_raw, it_fixed;
    logic [XLEN:0]   rem_sh, diff, it_acc;
    logic [4:0]      sh;
    logic            is_long;

    // Single-cycle ALU result.
    always_comb begin
        alu_res = '0;
        sh      = bus.B[4:0];
        case (bus.op)
            OP_ADD:  alu_res = bus.A + bus.B;
            OP_SUB:  alu_res = bus.A - bus.B;
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_NOT:  alu_res = ~bus.B;
            OP_MOV:  alu_res = bus.B;
            OP_LSL:  alu_res = bus.A << sh;
            OP_LSR:  alu_res = bus.A >> sh;
            OP_ASR:  alu_res = XLEN'($signed(bus.A) >>> sh);
            default: alu_res = '0;
        endcase
    end

    assign is_long = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    // Magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign mag_a = bus.A[XLEN-1] ? (~bus.A + XLEN'(1)) : bus.A;
    assign mag_b = bus.B[XLEN-1] ? (~bus.B + XLEN'(1)) : bus.B;

    // One iteration: shift-add multiply, or one restoring-division step
    // (opa holds dividend bits shifting out and quotient bits shifting in).
    always_comb begin
        mul_sum  = acc_q[XLEN-1:0] + (opb_q[0] ? opa_q : '0);
        rem_sh   = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        diff     = rem_sh - {1'b0, opb_q};
        it_a     = opa_q;
        it_b     = opb_q;
        it_acc   = acc_q;
        it_raw   = '0;
        if (op_q == OP_MUL) begin
            it_acc = {1'b0, mul_sum};
            it_a   = opa_q << 1;
            it_b   = opb_q >> 1;
            it_raw = mul_sum;
        end else begin
            if (!diff[XLEN]) begin
                it_acc = diff;
                it_a   = {opa_q[XLEN-2:0], 1'b1};
            end else begin
                it_acc = rem_sh;
                it_a   = {opa_q[XLEN-2:0], 1'b0};
            end
            it_raw = (op_q == OP_DIV) ? it_a : it_acc[XLEN-1:0];
        end
        it_fixed = neg_q ? (~it_raw + XLEN'(1)) : it_raw;
        // Divide by zero yields all ones regardless of the dividend sign.
        if ((op_q == OP_DIV) && dz_q) begin
            it_fixed = '1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt_q;
        op_n     = op_q;
        neg_n    = neg_q;
        dz_n     = dz_q;
        rd_n     = rd_q;
        opa_n    = opa_q;
        opb_n    = opb_q;
        acc_n    = acc_q;
        valid_n  = 1'b0;
        rd_dm_n  = '0;
        result_n = result_q;
        fe_n     = fe_q;
        fgt_n    = fgt_q;
        if (bus.flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_long) begin
                            state_n = BUSY;
                            cnt_n   = CNTW'(31);
                            op_n    = bus.op;
                            rd_n    = bus.rd_ALU;
                            opa_n   = mag_a;
                            opb_n   = mag_b;
                            acc_n   = '0;
                            dz_n    = (bus.B == '0);
                            // Remainder follows the dividend sign; mul/div follow sign(A)^sign(B).
                            neg_n   = (bus.op == OP_MOD) ? bus.A[XLEN-1]
                                                         : (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
                        end else begin
                            valid_n  = 1'b1;
                            rd_dm_n  = bus.rd_ALU;
                            result_n = alu_res;
                            if (bus.op == OP_CMP) begin
                                fe_n  = (bus.A == bus.B);
                                fgt_n = ($signed(bus.A) > $signed(bus.B));
                            end
                        end
                    end
                end
                BUSY: begin
                    opa_n = it_a;
                    opb_n = it_b;
                    acc_n = it_acc;
                    if (cnt_q == '0) begin
                        state_n  = IDLE;
                        valid_n  = 1'b1;
                        rd_dm_n  = rd_q;
                        result_n = it_fixed;
                    end else begin
                        cnt_n = cnt_q - CNTW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            rd_dm_q  <= '0;
            result_q <= '0;
            fe_q     <= 1'b0;
            fgt_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt_q    <= cnt_n;
            op_q     <= op_n;
            neg_q    <= neg_n;
            dz_q     <= dz_n;
            rd_q     <= rd_n;
            opa_q    <= opa_n;
            opb_q    <= opb_n;
            acc_q    <= acc_n;
            valid_q  <= valid_n;
            rd_dm_q  <= rd_dm_n;
            result_q <= result_n;
            fe_q     <= fe_n;
            fgt_q    <= fgt_n;
        end
    end

    assign bus.stall     = (state == BUSY);
    assign bus.valid_DM  = valid_q;
    assign bus.rd_DM     = rd_dm_q;
    assign bus.result_DM = result_q;
    assign bus.flag_E    = fe_q;
    assign bus.flag_GT   = fgt_q;
endmodule
